pipe_skid_stage: RTL and testbench

Parametrised elastic pipeline register for the core's inter-stage boundaries (IF/ID first, then ID/EX and onward), replacing the stall-vector-driven flops with a valid/ready handshake. Two-entry skid buffer: full throughput, one-cycle latency, and a registered `in_ready` that breaks the combinational back-pressure path. A synchronous flush kills all contents. Invalid slots present an all-zero bubble payload, matching the existing NOP-on-stall convention.

---
 rtl/pipe_skid_stage_pkg.sv | 18 +
 rtl/pipe_skid_stage.sv | 86 ++++++++
 tb/tb_pipe_skid_stage.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for the elastic pipeline register: state encodings
// and the bus widths of the IF/ID boundary payload.
package pipe_skid_stage_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;
  localparam int IfIdBusW    = InstAddrBus + InstBus + 1;

  localparam logic        RstEnable = 1'b1;
  localparam logic [31:0] ZeroWord  = 32'h0000_0000;

  typedef enum logic [1:0] {
    PSS_EMPTY = 2'd0,
    PSS_BUSY  = 2'd1,
    PSS_FULL  = 2'd2
  } pss_state_e;

endpackage

// File: rtl/pipe_skid_stage.sv
// Two-entry skid-buffer pipeline register with valid/ready handshake,
// registered in_ready, synchronous flush and zero bubble payload.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int DATA_W = IfIdBusW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  pss_state_e        state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic              in_fire, out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      PSS_EMPTY: begin
        if (in_fire) begin
          main_d  = in_data;
          state_d = PSS_BUSY;
        end
      end
      PSS_BUSY: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          skid_d  = in_data;
          state_d = PSS_FULL;
        end else if (out_fire) begin
          main_d  = '0;
          state_d = PSS_EMPTY;
        end
      end
      PSS_FULL: begin
        // in_ready is low here, so only the drain side can move.
        if (out_fire) begin
          main_d  = skid_q;
          skid_d  = '0;
          state_d = PSS_BUSY;
        end
      end
      default: begin
        main_d  = '0;
        skid_d  = '0;
        state_d = PSS_EMPTY;
      end
    endcase
    // Flush and reset both discard everything, including a same-cycle in_fire.
    if (rst == RstEnable || flush) begin
      main_d  = '0;
      skid_d  = '0;
      state_d = PSS_EMPTY;
    end
    in_ready_d = (state_d != PSS_FULL);
  end

  always_ff @(posedge clk) begin
    state_q    <= state_d;
    main_q     <= main_d;
    skid_q     <= skid_d;
    in_ready_q <= in_ready_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != PSS_EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed and randomised checks of the pipe_skid_stage handshake,
// ordering, flush behaviour and bubble payload.
module tb_pipe_skid_stage;

  localparam int W = 65;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(.DATA_W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .occupancy(occupancy)
  );

  // Inputs change on the falling edge; the rising edge in between samples them.
  task automatic cycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [W-1:0] w;
    w = 65'h1_0000_0004_0000_0013;
    rst = 1'b1; in_valid = 1'b1; in_data = 65'h1_2345; out_ready = 1'b0;
    cycle(); cycle();
    rst = 1'b0; in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
    n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", occupancy); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    in_valid = 1'b1; in_data = w; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0; in_data = 'x;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fill_out_valid got %0b want 1", out_valid); end
    n_checks++; if (out_data !== w) begin n_fail++; $display("FAIL fill_out_data got %h want %h", out_data, w); end
    n_checks++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL fill_occ got %0d want 1", occupancy); end
    cycle();
    n_checks++; if (out_valid !== 1'b0 || out_data !== '0) begin n_fail++; $display("FAIL fill_drain got v=%0b d=%h want v=0 d=0", out_valid, out_data); end
  endtask

  task automatic test_skid();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 65'd1;
    cycle();
    n_checks++; if (out_data !== 65'd1 || occupancy !== 2'd1) begin n_fail++; $display("FAIL skid_w1 got d=%0d occ=%0d want d=1 occ=1", out_data, occupancy); end
    out_ready = 1'b0; in_data = 65'd2;
    cycle();
    n_checks++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL skid_occ2 got %0d want 2", occupancy); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL skid_in_ready got %0b want 0", in_ready); end
    n_checks++; if (out_data !== 65'd1) begin n_fail++; $display("FAIL skid_head got %0d want 1", out_data); end
    in_data = 65'd3;
    cycle();
    n_checks++; if (occupancy !== 2'd2 || out_data !== 65'd1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL skid_hold got occ=%0d d=%0d rdy=%0b want occ=2 d=1 rdy=0", occupancy, out_data, in_ready); end
    out_ready = 1'b1;
    cycle();
    n_checks++; if (out_data !== 65'd2 || occupancy !== 2'd1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL skid_rel got d=%0d occ=%0d rdy=%0b want d=2 occ=1 rdy=1", out_data, occupancy, in_ready); end
    cycle();
    n_checks++; if (out_data !== 65'd3 || occupancy !== 2'd1) begin n_fail++; $display("FAIL skid_w3 got d=%0d occ=%0d want d=3 occ=1", out_data, occupancy); end
    in_valid = 1'b0; in_data = 'x;
    cycle();
    n_checks++; if (out_valid !== 1'b0 || out_data !== '0 || occupancy !== 2'd0) begin n_fail++; $display("FAIL skid_empty got v=%0b d=%h occ=%0d want 0 0 0", out_valid, out_data, occupancy); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = W'(i);
      cycle();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== W'(i) || occupancy > 2'd1 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_%0d got v=%0b d=%0d occ=%0d rdy=%0b want v=1 d=%0d occ<=1 rdy=1", i, out_valid, out_data, occupancy, in_ready, i);
      end
    end
    in_valid = 1'b0; in_data = 'x;
    cycle();
    n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL stream_end_occ got %0d want 0", occupancy); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 65'hA;
    cycle();
    in_data = 65'hB;
    cycle();
    n_checks++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL flush_setup_occ got %0d want 2", occupancy); end
    flush = 1'b1; in_data = 65'hC; out_ready = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0; in_data = 'x;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_full_valid got %0b want 0", out_valid); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL flush_full_data got %h want 0", out_data); end
    n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL flush_full_occ got %0d want 0", occupancy); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_full_in_ready got %0b want 1", in_ready); end
    cycle();
    n_checks++; if (out_valid !== 1'b0 || out_data !== '0) begin n_fail++; $display("FAIL flush_no_replay got v=%0b d=%h want 0 0", out_valid, out_data); end
    // Flush from one entry with a live in_fire: the offered word is dropped.
    in_valid = 1'b1; in_data = 65'hD;
    cycle();
    flush = 1'b1; in_data = 65'hE; out_ready = 1'b0;
    cycle();
    flush = 1'b0; in_valid = 1'b0; in_data = 'x;
    n_checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin n_fail++; $display("FAIL flush_busy got v=%0b occ=%0d want 0 0", out_valid, occupancy); end
    // Reset mid-FULL also empties both entries in one cycle.
    in_valid = 1'b1; in_data = 65'h11;
    cycle();
    in_data = 65'h12;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0; in_valid = 1'b0; in_data = 'x;
    n_checks++; if (occupancy !== 2'd0 || out_data !== '0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_full got occ=%0d d=%h rdy=%0b want 0 0 1", occupancy, out_data, in_ready); end
  endtask

  task automatic test_random();
    logic [W-1:0] q[$];
    logic [W-1:0] d, exp_d;
    logic iv, ordy;
    int unsigned seq;
    int mism;
    seq = 0; mism = 0;
    in_valid = 1'b0; out_ready = 1'b0; in_data = 'x;
    cycle();
    for (int c = 0; c < 10200; c++) begin
      n_checks++;
      if (!out_valid && out_data !== '0) begin n_fail++; mism++; if (mism < 10) $display("FAIL rnd_bubble c=%0d got %h want 0", c, out_data); end
      n_checks++;
      if (int'(occupancy) != q.size() || out_valid !== (q.size() != 0)) begin n_fail++; mism++; if (mism < 10) $display("FAIL rnd_occ c=%0d got occ=%0d v=%0b want occ=%0d", c, occupancy, out_valid, q.size()); end
      n_checks++;
      if (in_ready !== (q.size() < 2)) begin n_fail++; mism++; if (mism < 10) $display("FAIL rnd_in_ready c=%0d got %0b with %0d held", c, in_ready, q.size()); end
      if (c < 10000) begin
        iv   = ($urandom_range(0, 3) != 0);
        ordy = ($urandom_range(0, 2) != 0);
      end else begin
        iv   = 1'b0;
        ordy = 1'b1;
      end
      if (out_valid && ordy) begin
        exp_d = (q.size() != 0) ? q.pop_front() : '0;
        n_checks++;
        if (out_data !== exp_d) begin n_fail++; mism++; if (mism < 10) $display("FAIL rnd_order c=%0d got %h want %h", c, out_data, exp_d); end
      end
      d = {seq[0], seq, ~seq};
      if (iv && in_ready) begin
        q.push_back(d);
        seq++;
      end
      in_valid = iv; out_ready = ordy; in_data = iv ? d : 'x;
      cycle();
    end
    n_checks++;
    if (q.size() != 0 || seq < 100) begin n_fail++; $display("FAIL rnd_drain got %0d left after %0d words want 0 left", q.size(), seq); end
  endtask

  initial begin
    test_reset();
    test_skid();
    test_back_to_back();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
